// File: rtl/gcd_sched_pkg.sv
// Shared types and helpers for the gcd_sched round-robin engine scheduler.
package gcd_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    // Index width for n requesters; n is at least 2 so $clog2 never yields 0.
    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Requester-side bus of gcd_sched: operand requests in, grants and results out.
interface gcd_sched_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 32
);
    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] a_in;
    logic [NREQ*NBITS-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       resp_valid;
    logic [NBITS-1:0]      resp_result;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, resp_valid, resp_result, resp_err, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, resp_valid, resp_result, resp_err, busy
    );
endinterface

// File: rtl/gcd_sched_rr_picker.sv
// Combinational round-robin arbiter: first active request after last_id wins.
module rr_picker
    import gcd_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_id,
    output logic             any,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] cand;
    logic             take;

    // Scan positions last_id+1 .. last_id+NREQ (mod NREQ); the first hit is taken.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        take  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            pos         = (int'(last_id) + i) % NREQ;
            cand        = IDX_W'(pos);
            take        = !any && req[cand];
            grant[cand] = grant[cand] | take;
            idx         = take ? cand : idx;
            any         = any | take;
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: shares one gcd engine among NREQ requesters in round-robin order.
// Optional watchdog on engine run time enabled by GCD_SCHED_TIMEOUT_EN.
module gcd_sched
    import gcd_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NBITS   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    gcd_sched_if.slave       bus,
    output logic             eng_start,
    output logic [NBITS-1:0] eng_a,
    output logic [NBITS-1:0] eng_b,
    output logic             eng_reset_n,
    input  logic             eng_done,
    input  logic [NBITS-1:0] eng_result
);

    localparam int IDX_W = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_sched: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    sched_state_t     state_r;
    sched_state_t     state_s;
    logic [IDX_W-1:0] cur_id_r;
    logic [IDX_W-1:0] last_id_r;
    logic [NREQ-1:0]  cur_onehot_s;

    logic             pick_any_s;
    logic [NREQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [NBITS-1:0] a_sel_s;
    logic [NBITS-1:0] b_sel_s;

    logic [NREQ-1:0]  gnt_s;
    logic [NREQ-1:0]  resp_valid_s;
    logic             eng_start_s;
    logic             resp_err_s;
    logic             busy_s;
    logic             load_ops_s;
    logic             cap_res_s;
    logic [NBITS-1:0] res_s;
    logic             wait_end_s;
    logic             wd_fire_s;

    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  resp_valid_r;
    logic [NBITS-1:0] resp_result_r;
    logic             resp_err_r;
    logic             busy_r;
    logic             eng_start_r;
    logic [NBITS-1:0] eng_a_r;
    logic [NBITS-1:0] eng_b_r;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (bus.req),
        .last_id (last_id_r),
        .any     (pick_any_s),
        .grant   (pick_onehot_s),
        .idx     (pick_idx_s)
    );

    assign a_sel_s      = bus.a_in[pick_idx_s*NBITS +: NBITS];
    assign b_sel_s      = bus.b_in[pick_idx_s*NBITS +: NBITS];
    assign cur_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << cur_id_r;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             wd_fire_r;
    logic             wd_hit_s;

    // Watchdog fires after TIMEOUT WAIT cycles; the fire cycle itself holds the engine in reset.
    assign wd_hit_s = (state_r == S_WAIT) && !wd_fire_r && !eng_done &&
                      (wait_cnt_r == CNT_W'(TIMEOUT - 1));

    // WAIT-cycle counter and one-cycle watchdog pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
            wd_fire_r  <= 1'b0;
        end else begin
            wd_fire_r <= wd_hit_s;
            if (state_r == S_WAIT && !wd_fire_r) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= '0;
            end
        end
    end

    assign wd_fire_s   = wd_fire_r;
    assign eng_reset_n = ~reset & ~wd_fire_r;
`else
    assign wd_fire_s   = 1'b0;
    assign eng_reset_n = ~reset;
`endif

    assign wait_end_s = eng_done | wd_fire_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pick_any_s) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: state_s = S_WAIT;
            S_WAIT: begin
                if (wait_end_s) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RESP:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, aligned with state_s.
    always_comb begin
        gnt_s        = '0;
        resp_valid_s = '0;
        eng_start_s  = 1'b0;
        resp_err_s   = 1'b0;
        load_ops_s   = 1'b0;
        cap_res_s    = 1'b0;
        res_s        = '0;
        case (state_r)
            S_IDLE: begin
                load_ops_s  = pick_any_s;
                gnt_s       = pick_onehot_s;
                eng_start_s = pick_any_s;
            end
            S_WAIT: begin
                cap_res_s    = wait_end_s;
                resp_valid_s = wait_end_s ? cur_onehot_s : '0;
                resp_err_s   = wd_fire_s;
                res_s        = wd_fire_s ? '0 : eng_result;
            end
            default: begin
                gnt_s = '0;
            end
        endcase
        busy_s = (state_s != S_IDLE);
    end

    // Output, operand and bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_r         <= '0;
            resp_valid_r  <= '0;
            resp_result_r <= '0;
            resp_err_r    <= 1'b0;
            busy_r        <= 1'b0;
            eng_start_r   <= 1'b0;
            eng_a_r       <= '0;
            eng_b_r       <= '0;
            cur_id_r      <= '0;
            last_id_r     <= IDX_W'(NREQ - 1);
        end else begin
            gnt_r        <= gnt_s;
            resp_valid_r <= resp_valid_s;
            resp_err_r   <= resp_err_s;
            busy_r       <= busy_s;
            eng_start_r  <= eng_start_s;
            if (load_ops_s) begin
                eng_a_r  <= a_sel_s;
                eng_b_r  <= b_sel_s;
                cur_id_r <= pick_idx_s;
            end
            if (state_r == S_ISSUE) begin
                last_id_r <= cur_id_r;
            end
            if (cap_res_s) begin
                resp_result_r <= res_s;
            end
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.resp_valid  = resp_valid_r;
    assign bus.resp_result = resp_result_r;
    assign bus.resp_err    = resp_err_r;
    assign bus.busy        = busy_r;
    assign eng_start       = eng_start_r;
    assign eng_a           = eng_a_r;
    assign eng_b           = eng_b_r;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed self-checking bench for gcd_sched with a subtractive gcd engine model.
module tb_gcd_sched;

    localparam int NREQ    = 4;
    localparam int NBITS   = 32;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gcd_sched_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

    logic             eng_start;
    logic             eng_reset_n;
    logic             eng_done;
    logic [NBITS-1:0] eng_a;
    logic [NBITS-1:0] eng_b;
    logic [NBITS-1:0] eng_result;

    gcd_sched #(.NREQ(NREQ), .NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .eng_start   (eng_start),
        .eng_a       (eng_a),
        .eng_b       (eng_b),
        .eng_reset_n (eng_reset_n),
        .eng_done    (eng_done),
        .eng_result  (eng_result)
    );

    // Subtractive gcd engine, one step per cycle; gcd(x,0)=x, gcd(0,y)=y.
    logic [NBITS-1:0] ea;
    logic [NBITS-1:0] eb;
    logic             erun;
    always @(posedge clk or negedge eng_reset_n) begin
        if (!eng_reset_n) begin
            erun       <= 1'b0;
            eng_done   <= 1'b0;
            eng_result <= '0;
            ea         <= '0;
            eb         <= '0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                ea   <= eng_a;
                eb   <= eng_b;
                erun <= 1'b1;
            end else if (erun) begin
                if (eb == '0 || ea == eb) begin
                    eng_result <= ea;
                    eng_done   <= 1'b1;
                    erun       <= 1'b0;
                end else if (ea == '0) begin
                    eng_result <= eb;
                    eng_done   <= 1'b1;
                    erun       <= 1'b0;
                end else if (ea > eb) begin
                    ea <= ea - eb;
                end else begin
                    eb <= eb - ea;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.a_in[i*NBITS +: NBITS] = a;
        bus.b_in[i*NBITS +: NBITS] = b;
    endtask

    task automatic wait_gnt(input int budget, output logic [NREQ-1:0] g);
        g = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                g = bus.gnt;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int budget, output logic [NREQ-1:0] v,
                             output logic [31:0] r, output logic e);
        v = '0;
        r = '0;
        e = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) begin
                v = bus.resp_valid;
                r = bus.resp_result;
                e = bus.resp_err;
                break;
            end
        end
    endtask

    // One full job: grant one cycle after IDLE sees the request, then a single result pulse.
    task automatic job(input string tag, input logic [NREQ-1:0] exp_g,
                       input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic [31:0] exp_r);
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] v;
        logic [31:0]     r;
        logic            e;
        wait_gnt(1, g);
        chk({tag, " gnt"}, 32'(g), 32'(exp_g));
        chk({tag, " eng_start"}, 32'(eng_start), 32'd1);
        chk({tag, " eng_a"}, eng_a, exp_a);
        chk({tag, " eng_b"}, eng_b, exp_b);
        bus.req = bus.req & ~g;
        @(negedge clk);
        chk({tag, " busy in wait"}, 32'(bus.busy), 32'd1);
        wait_resp(300, v, r, e);
        chk({tag, " resp_valid"}, 32'(v), 32'(exp_g));
        chk({tag, " resp_result"}, r, exp_r);
        chk({tag, " resp_err"}, 32'(e), 32'd0);
        @(negedge clk);
        chk({tag, " resp_valid drop"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, " busy idle"}, 32'(bus.busy), 32'd0);
    endtask

    logic [NREQ-1:0] g_l;
    logic [NREQ-1:0] v_l;
    logic [31:0]     r_l;
    logic            e_l;
    logic            seen;
    int              n_l;

    initial begin
        reset    = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst gnt", 32'(bus.gnt), 32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst eng_start", 32'(eng_start), 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst resp_result", bus.resp_result, 32'd0);
        chk("rst eng_a", eng_a, 32'd0);
        chk("rst eng_reset_n", 32'(eng_reset_n), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("eng_reset_n released", 32'(eng_reset_n), 32'd1);

        // All four requesters at once: served 0,1,2,3.
        set_ops(0, 32'd12, 32'd8);
        set_ops(1, 32'd9,  32'd6);
        set_ops(2, 32'd35, 32'd14);
        set_ops(3, 32'd17, 32'd5);
        bus.req = 4'b1111;
        job("all r0", 4'b0001, 32'd12, 32'd8,  32'd4);
        job("all r1", 4'b0010, 32'd9,  32'd6,  32'd3);
        job("all r2", 4'b0100, 32'd35, 32'd14, 32'd7);
        job("all r3", 4'b1000, 32'd17, 32'd5,  32'd1);

        // Single requester.
        set_ops(1, 32'd48, 32'd18);
        bus.req = 4'b0010;
        job("single", 4'b0010, 32'd48, 32'd18, 32'd6);

        // Zero operand on requester 2, leaving last_id at 2.
        set_ops(2, 32'd7, 32'd0);
        bus.req = 4'b0100;
        job("zero b", 4'b0100, 32'd7, 32'd0, 32'd7);

        // Rotation from last_id=2: requester 3 before requester 0.
        set_ops(3, 32'd35, 32'd14);
        set_ops(0, 32'd0, 32'd0);
        bus.req = 4'b1001;
        job("rot r3", 4'b1000, 32'd35, 32'd14, 32'd7);
        job("rot zz", 4'b0001, 32'd0,  32'd0,  32'd0);

        // Reset in the middle of WAIT.
        set_ops(0, 32'd1000, 32'd1);
        bus.req = 4'b0001;
        wait_gnt(1, g_l);
        chk("mid gnt", 32'(g_l), 32'd1);
        bus.req = '0;
        repeat (5) @(negedge clk);
        chk("mid busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        chk("mid rst eng_a", eng_a, 32'd0);
        chk("mid rst eng_b", eng_b, 32'd0);
        chk("mid rst eng_reset_n", 32'(eng_reset_n), 32'd0);
        chk("mid rst resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            seen = seen | (bus.resp_valid != '0);
        end
        chk("mid no stale resp", 32'(seen), 32'd0);
        set_ops(2, 32'd12, 32'd8);
        bus.req = 4'b0100;
        job("after rst", 4'b0100, 32'd12, 32'd8, 32'd4);

`ifdef GCD_SCHED_TIMEOUT_EN
        // Engine would take ~4e9 steps; the watchdog ends the job.
        set_ops(1, 32'hFFFF_FFFF, 32'd1);
        bus.req = 4'b0010;
        wait_gnt(1, g_l);
        chk("to gnt", 32'(g_l), 32'd2);
        bus.req = '0;
        n_l = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            n_l++;
            if (!eng_reset_n) break;
        end
        chk("to wait cycles", 32'(n_l), 32'd65);
        wait_resp(1, v_l, r_l, e_l);
        chk("to resp_valid", 32'(v_l), 32'd2);
        chk("to resp_err", 32'(e_l), 32'd1);
        chk("to resp_result", r_l, 32'd0);
        chk("to eng_reset_n back", 32'(eng_reset_n), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
